// File: rtl/seq_left_shifter_if.sv
// Request/result handshake bundle for the sequential left shifter.
// The master side issues operands and acknowledges results; the slave side is the shifter.
interface seq_left_shifter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [31:0]      shamt;
    logic             flush;
    logic             ready;
    logic             busy;
    logic [WIDTH-1:0] res;
    logic             res_valid;
    logic             res_ack;

    modport master (
        output start, A, shamt, flush, res_ack,
        input  ready, busy, res, res_valid
    );

    modport slave (
        input  start, A, shamt, flush, res_ack,
        output ready, busy, res, res_valid
    );
endinterface

// File: rtl/seq_left_shifter.sv
// Multi-cycle logical left shifter: one bit per clock, zero fill from the LSB.
// start/ready accepts an operand, res_valid/res_ack returns the result; flush aborts.
module seq_left_shifter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    seq_left_shifter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [31:0]      WIDTH_AMT = 32'(WIDTH);
    localparam logic [CNT_W-1:0] WIDTH_CNT = CNT_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] start_count;

    // The full 32-bit amount is compared, so large values saturate rather than wrap.
    always_comb begin
        start_count = WIDTH_CNT;
        if (bus.shamt < WIDTH_AMT)
            start_count = CNT_W'(bus.shamt);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            res   <= '0;
            count <= '0;
        end else if (bus.flush) begin
            // Abort keeps the partially shifted value in res; only the state returns.
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        res   <= bus.A;
                        count <= start_count;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count == '0) begin
                        state <= DONE;
                    end else begin
                        res   <= {res[WIDTH-2:0], 1'b0};
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.busy      = (state == SHIFT);
    assign bus.res_valid = (state == DONE);
    assign bus.res       = res;
endmodule

// File: doc/seq_left_shifter.md
Name: seq_left_shifter

Overview:
- Multi-cycle logical left-shift unit for the KGP_RISC execute stage. It is the complement of the existing single-cycle arithmetic right shifter.
- Shifts the operand left by one bit per clock, zero-filling from the LSB.
- Uses a start/ready request handshake and a valid/ack result handshake, so the control FSM can stall on it.
- Intended for area-constrained builds that drop the combinational left barrel shifter.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, width of the internal shift counter; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- A  input  WIDTH  operand, sampled on the accepting edge.
- shamt  input  32  shift amount, unsigned, sampled on the accepting edge.
- flush  input  1  synchronous abort from the pipeline control.
- ready  output  1  unit is idle and can accept start.
- busy  output  1  shift in progress.
- res  output  WIDTH  shift register contents; final result when res_valid=1.
- res_valid  output  1  result is available.
- res_ack  input  1  consumer has taken the result.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, res=0, count=0.
  - ready=1, busy=0, res_valid=0.
  - Reset asserted mid-operation discards the operation immediately, with no result.
- States: IDLE, SHIFT, DONE. Outputs are decoded from registered state only:
  - ready = (state==IDLE)
  - busy = (state==SHIFT)
  - res_valid = (state==DONE)
- IDLE:
  - On an edge with start=1: res<=A, count<=min(shamt, WIDTH), state<=SHIFT.
  - shamt >= WIDTH saturates the count to WIDTH, so the result is 0.
  - With start=0, all registers hold.
- SHIFT, on each edge:
  - If count==0, state<=DONE.
  - Otherwise res<={res[WIDTH-2:0],1'b0} and count<=count-1.
- Latency: effective amount n=min(shamt,WIDTH). res_valid rises on the (n+2)th rising edge, counting the accepting edge as edge 1.
  - n=0 gives 2 cycles.
  - n=32 gives 34 cycles.
- DONE:
  - res is frozen and res_valid is held high until res_ack=1.
  - On the edge with res_ack=1, state<=IDLE and res holds its value; ready=1 from the next cycle.
  - start cannot be accepted in the same cycle as res_ack, because ready=0 in DONE.
  - res_ack in IDLE or SHIFT is ignored.
- start in SHIFT or DONE is ignored and not queued; A and shamt may change freely while busy.
- flush:
  - In SHIFT or DONE: state<=IDLE and res_valid drops on that edge; res keeps its partial value.
  - In IDLE: flush has priority over start, so the request is dropped.
- Priority on any edge: rst > flush > normal transition.
- Arithmetic:
  - Logical shift only; bits shifted out of bit WIDTH-1 are lost and no flags are produced.
  - All 32 bits of shamt count toward the comparison with WIDTH, so 32'h0000_0100 yields a result of 0.

Test Plan:
- Reset mid-shift: start with A=32'hFFFF_FFFF, shamt=10, assert rst at edge 4 -> ready=1, busy=0, res_valid=0 and res=0 immediately; no result ever appears.
- Basic shift: A=32'h0000_0001, shamt=5 -> res_valid rises at edge 7, res=32'h0000_0020; after res_ack, ready=1 next cycle.
- Zero amount and full-width amounts:
  - shamt=0, A=32'hDEAD_BEEF -> res_valid at edge 2, res=32'hDEAD_BEEF.
  - shamt=31, A=32'h0000_0003 -> res=32'h8000_0000.
  - shamt=32 or 32'hFFFF_FFFF -> res=0, res_valid at edge 34.
- Handshake backpressure: hold res_ack=0 for 10 cycles in DONE, pulse start and change A and shamt -> res and res_valid stable, start ignored; ack -> IDLE.
- Flush: A=32'h1, shamt=20, flush at edge 6 -> ready=1 next cycle, res_valid never asserted. Flush with start in IDLE -> no operation is started.
- Back-to-back: ack, then start on the first ready cycle with A=32'h8000_0001, shamt=1 -> res=32'h0000_0002 at edge 3 after acceptance.
